// File: rtl/led_matrix_pwm.sv
// Multiplexed ROWS x COLS LED matrix scanner with per-LED PWM brightness.
// Host frames are double-buffered and promoted to the display only at the frame boundary.
module led_matrix_pwm #(
    parameter int unsigned ROWS     = 4,
    parameter int unsigned COLS     = 4,
    parameter int unsigned PWM_BITS = 4,
    parameter int unsigned SCAN_DIV = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en,
    input  logic [ROWS*COLS*PWM_BITS-1:0]     pixels,
    input  logic                              load,
    output logic                              pending,
    output logic                              frame_sync,
    output logic [ROWS-1:0]                   aled,
    output logic [COLS-1:0]                   kled_tri
);

    localparam int unsigned FW = ROWS * COLS * PWM_BITS;
    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [PW-1:0] P_MAX = PW'(SCAN_DIV - 1);
    localparam logic [RW-1:0] R_MAX = RW'(ROWS - 1);
    localparam logic [CW-1:0] C_MAX = CW'(COLS - 1);

    logic [PW-1:0]       p;
    logic [PWM_BITS-1:0] t;
    logic [RW-1:0]       row;
    logic [CW-1:0]       col;
    logic [FW-1:0]       active;
    logic [FW-1:0]       shadow;

    logic                p_wrap_c;
    logic                t_wrap_c;
    logic                boundary_c;
    logic                lit_c;
    logic [PWM_BITS-1:0] level_c;
    int unsigned         slot_c;

    // Slot index is kept as separate row/col counters; slot = row + ROWS*col.
    always_comb begin
        p_wrap_c   = (p == P_MAX);
        t_wrap_c   = p_wrap_c && (t == '1);
        boundary_c = t_wrap_c && (row == R_MAX) && (col == C_MAX);
        slot_c     = 32'(row) + ROWS * 32'(col);
        level_c    = PWM_BITS'(active >> (slot_c * PWM_BITS));
        lit_c      = en && (t < level_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p          <= '0;
            t          <= '0;
            row        <= '0;
            col        <= '0;
            active     <= '0;
            shadow     <= '0;
            pending    <= 1'b0;
            frame_sync <= 1'b0;
            aled       <= '1;
            kled_tri   <= '0;
        end else begin
            p <= p_wrap_c ? '0 : p + PW'(1);
            if (p_wrap_c) begin
                t <= t + PWM_BITS'(1);
            end
            if (t_wrap_c) begin
                if (row == R_MAX) begin
                    row <= '0;
                    col <= (col == C_MAX) ? '0 : col + CW'(1);
                end else begin
                    row <= row + RW'(1);
                end
            end

            // Promotion reads the old shadow, so a load on the boundary waits a frame.
            if (boundary_c && pending) begin
                active <= shadow;
            end
            if (load) begin
                shadow  <= pixels;
                pending <= 1'b1;
            end else if (boundary_c) begin
                pending <= 1'b0;
            end

            frame_sync <= boundary_c;
            aled       <= ~(ROWS'(1) << row);
            kled_tri   <= lit_c ? (COLS'(1) << col) : '0;
        end
    end

endmodule

// File: tb/tb_led_matrix_pwm.sv
// Randomised and directed bench for led_matrix_pwm against a cycle-count based model.
module tb_led_matrix_pwm;

    localparam int unsigned ROWS  = 4;
    localparam int unsigned COLS  = 4;
    localparam int unsigned PB    = 4;
    localparam int unsigned SD    = 2;
    localparam int unsigned NLED  = ROWS * COLS;
    localparam int unsigned FW    = NLED * PB;
    localparam int unsigned SLOT  = (1 << PB) * SD;
    localparam int unsigned FRAME = NLED * SLOT;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          load;
    logic [FW-1:0] pixels;
    logic          pending;
    logic          frame_sync;
    logic [ROWS-1:0] aled;
    logic [COLS-1:0] kled_tri;

    int errors = 0;
    int checks = 0;

    // Model state: cycle count since reset plus the two frame buffers.
    int            n;
    logic [FW-1:0] m_active;
    logic [FW-1:0] m_shadow;
    logic          m_pend;
    logic [ROWS-1:0] x_aled;
    logic [COLS-1:0] x_kled;
    logic          x_fs;

    led_matrix_pwm #(
        .ROWS(ROWS), .COLS(COLS), .PWM_BITS(PB), .SCAN_DIV(SD)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .pixels(pixels), .load(load),
        .pending(pending), .frame_sync(frame_sync), .aled(aled), .kled_tri(kled_tri)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic e, input logic l, input logic [FW-1:0] px);
        int s;
        int tk;
        int lvl;
        logic boundary;
        rst = r; en = e; load = l; pixels = px;
        @(posedge clk);
        if (r) begin
            n = 0; m_active = '0; m_shadow = '0; m_pend = 1'b0;
            x_aled = '1; x_kled = '0; x_fs = 1'b0;
        end else begin
            s   = (n / SLOT) % NLED;
            tk  = (n / SD) % (1 << PB);
            lvl = int'(m_active[s*PB +: PB]);
            x_aled = ~(ROWS'(1) << (s % ROWS));
            x_kled = (e && tk < lvl) ? (COLS'(1) << (s / ROWS)) : '0;
            boundary = ((n % FRAME) == FRAME - 1);
            x_fs = boundary;
            if (boundary && m_pend) m_active = m_shadow;
            if (l) begin
                m_shadow = px; m_pend = 1'b1;
            end else if (boundary) begin
                m_pend = 1'b0;
            end
            n++;
        end
        #1;
    endtask

    // Steps with load low until frame_sync is seen; cyc = steps taken, or -1 on timeout.
    task automatic wait_fs(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 2 * FRAME + 64; i++) begin
            step(1'b0, en, 1'b0, pixels);
            if (frame_sync === 1'b1) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int cnt;
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, '0);
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 1'b1, (i == 20), {FW{1'b1}});
            checks++;
            if ({aled, kled_tri, pending, frame_sync} !== {x_aled, x_kled, m_pend, x_fs}) begin
                errors++;
                $display("FAIL reset_prerun: got %b want %b", {aled, kled_tri, pending, frame_sync},
                         {x_aled, x_kled, m_pend, x_fs});
            end
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, '0);
            checks++;
            if ({aled, kled_tri, pending, frame_sync} !== {4'b1111, 4'b0000, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL reset_hold: got %b want %b", {aled, kled_tri, pending, frame_sync},
                         {4'b1111, 4'b0000, 1'b0, 1'b0});
            end
        end
        step(1'b0, 1'b1, 1'b0, '0);
        checks++;
        if ({aled, kled_tri} !== {4'b1110, 4'b0000}) begin
            errors++;
            $display("FAIL reset_first_edge: got %b want %b", {aled, kled_tri}, {4'b1110, 4'b0000});
        end
        wait_fs(cnt);
        checks++;
        if (cnt + 1 != 512) begin
            errors++;
            $display("FAIL reset_first_sync: got %0d want 512", cnt + 1);
        end
        wait_fs(cnt);
        checks++;
        if (cnt != 512) begin
            errors++;
            $display("FAIL reset_sync_period: got %0d want 512", cnt);
        end
    endtask

    task automatic test_single_led();
        logic [FW-1:0] px;
        int cyc;
        int on_cnt;
        int bad;
        px = '0;
        px[5*PB +: PB] = 4'd8;
        step(1'b0, 1'b1, 1'b1, px);
        checks++;
        if (pending !== 1'b1) begin
            errors++;
            $display("FAIL single_pending: got %b want 1", pending);
        end
        wait_fs(cyc);
        checks++;
        if (cyc < 0) begin
            errors++;
            $display("FAIL single_timeout: got no frame_sync want one");
        end
        on_cnt = 0; bad = 0;
        for (int k = 0; k < int'(FRAME); k++) begin
            step(1'b0, 1'b1, 1'b0, px);
            if (kled_tri == 4'b0010) begin
                on_cnt++;
                if (k / 32 != 5 || k % 32 >= 16 || aled != 4'b1101) bad++;
            end else if (kled_tri != 4'b0000) begin
                bad++;
            end
            if (k / 32 == 5 && aled != 4'b1101) bad++;
        end
        checks++;
        if (on_cnt != 16) begin
            errors++;
            $display("FAIL single_on_cycles: got %0d want 16", on_cnt);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL single_placement: got %0d stray cycles want 0", bad);
        end
    endtask

    task automatic test_levels();
        logic [FW-1:0] px;
        int cyc;
        int on_cnt [3];
        int bad;
        px = '0;
        px[0 +: PB] = 4'd0;
        px[PB +: PB] = 4'd1;
        px[2*PB +: PB] = 4'd15;
        step(1'b0, 1'b1, 1'b1, px);
        wait_fs(cyc);
        for (int r = 0; r < 3; r++) on_cnt[r] = 0;
        bad = 0;
        for (int k = 0; k < int'(FRAME); k++) begin
            step(1'b0, 1'b1, 1'b0, px);
            if ($countones(kled_tri) > 1 || $countones(~aled) != 1) bad++;
            if (kled_tri[0]) begin
                for (int r = 0; r < 3; r++) if (aled[r] == 1'b0) on_cnt[r]++;
            end
            checks++;
            if ({aled, kled_tri, pending, frame_sync} !== {x_aled, x_kled, m_pend, x_fs}) begin
                errors++;
                $display("FAIL levels_model: got %b want %b", {aled, kled_tri, pending, frame_sync},
                         {x_aled, x_kled, m_pend, x_fs});
            end
        end
        checks++;
        if (on_cnt[0] != 0) begin errors++; $display("FAIL level0_count: got %0d want 0", on_cnt[0]); end
        checks++;
        if (on_cnt[1] != 2) begin errors++; $display("FAIL level1_count: got %0d want 2", on_cnt[1]); end
        checks++;
        if (on_cnt[2] != 30) begin errors++; $display("FAIL level15_count: got %0d want 30", on_cnt[2]); end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL levels_onehot: got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_back_to_back();
        logic [FW-1:0] a;
        logic [FW-1:0] b;
        a = {$urandom, $urandom};
        b = ~a;
        step(1'b0, 1'b1, 1'b1, a);
        for (int i = 0; i < int'(FRAME) && (n % FRAME) != FRAME - 1; i++) step(1'b0, 1'b1, 1'b0, a);
        step(1'b0, 1'b1, 1'b1, b);
        checks++;
        if ({pending, frame_sync} !== 2'b11) begin
            errors++;
            $display("FAIL b2b_pending_kept: got %b want 11", {pending, frame_sync});
        end
        for (int k = 0; k < 2 * int'(FRAME) + 4; k++) begin
            step(1'b0, 1'b1, 1'b0, b);
            checks++;
            if ({aled, kled_tri, pending, frame_sync} !== {x_aled, x_kled, m_pend, x_fs}) begin
                errors++;
                $display("FAIL b2b_model: got %b want %b", {aled, kled_tri, pending, frame_sync},
                         {x_aled, x_kled, m_pend, x_fs});
            end
        end
    endtask

    task automatic test_last_load_wins();
        logic [FW-1:0] c;
        logic [FW-1:0] d;
        int fs_cnt;
        int lit;
        c = {FW{1'b1}};
        d = {$urandom, $urandom};
        step(1'b0, 1'b1, 1'b1, c);
        for (int i = 0; i < 50; i++) step(1'b0, 1'b1, 1'b0, c);
        step(1'b0, 1'b1, 1'b1, d);
        for (int k = 0; k < 2 * int'(FRAME); k++) begin
            step(1'b0, 1'b1, 1'b0, d);
            checks++;
            if ({aled, kled_tri, pending, frame_sync} !== {x_aled, x_kled, m_pend, x_fs}) begin
                errors++;
                $display("FAIL lastload_model: got %b want %b", {aled, kled_tri, pending, frame_sync},
                         {x_aled, x_kled, m_pend, x_fs});
            end
        end
        fs_cnt = 0; lit = 0;
        for (int k = 0; k < int'(FRAME); k++) begin
            step(1'b0, 1'b0, 1'b0, d);
            if (frame_sync) fs_cnt++;
            if (kled_tri != 4'b0000 && k > 0) lit++;
        end
        checks++;
        if (lit != 0) begin errors++; $display("FAIL en_off_dark: got %0d lit cycles want 0", lit); end
        checks++;
        if (fs_cnt != 1) begin errors++; $display("FAIL en_off_sync: got %0d pulses want 1", fs_cnt); end
    endtask

    task automatic test_full();
        logic [FW-1:0] px;
        int cyc;
        int slot_on [NLED];
        px = {FW{1'b1}};
        step(1'b0, 1'b1, 1'b1, px);
        wait_fs(cyc);
        wait_fs(cyc);
        for (int s = 0; s < int'(NLED); s++) slot_on[s] = 0;
        for (int k = 0; k < int'(FRAME); k++) begin
            step(1'b0, 1'b1, 1'b0, px);
            if (k == 0) begin
                checks++;
                if (aled !== 4'b1110) begin
                    errors++;
                    $display("FAIL full_wrap_row0: got %b want 1110", aled);
                end
            end
            if (kled_tri == (COLS'(1) << ((k / 32) / ROWS))) slot_on[k / 32]++;
        end
        for (int s = 0; s < int'(NLED); s++) begin
            checks++;
            if (slot_on[s] != 30) begin
                errors++;
                $display("FAIL full_slot_on slot%0d: got %0d want 30", s, slot_on[s]);
            end
        end
    endtask

    task automatic test_random();
        logic [FW-1:0] px;
        logic e;
        logic l;
        logic r;
        px = '0;
        for (int k = 0; k < 4000; k++) begin
            r = ($urandom_range(0, 1499) == 0);
            e = ($urandom_range(0, 7) != 0);
            l = ($urandom_range(0, 63) == 0);
            if (l) px = {$urandom, $urandom};
            step(r, e, l, px);
            checks++;
            if ({aled, kled_tri, pending, frame_sync} !== {x_aled, x_kled, m_pend, x_fs}) begin
                errors++;
                $display("FAIL random_model cyc%0d: got %b want %b", k, {aled, kled_tri, pending, frame_sync},
                         {x_aled, x_kled, m_pend, x_fs});
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; load = 1'b0; pixels = '0;
        test_reset();
        test_single_led();
        test_levels();
        test_back_to_back();
        test_last_load_wins();
        test_full();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_matrix_pwm.md
# led_matrix_pwm

Parametrised successor to the 4x4 LED matrix driver: it scans an ROWS x COLS multiplexed LED matrix one LED at a time and gives each LED a PWM_BITS-bit brightness level instead of on/off. Frames are double-buffered: a host-side load captures a new frame, and it becomes visible only at the frame boundary, so there is no tearing. It sits between the top-level status logic (e.g. synth activity indicators) and the anode pins and tristate cathode SB_IO enables.

## Interface
Parameters:
- ROWS, 4, number of anode lines (aled), ≥1
- COLS, 4, number of cathode lines (kled_tri), ≥1
- PWM_BITS, 4, brightness bits per LED, 1..8
- SCAN_DIV, 32, clk cycles per PWM tick, ≥1

Ports:
- clk  in  1  system clock (48 MHz HFOSC)
- rst  in  1  synchronous, active-high reset
- en  in  1  display enable; 0 forces all cathodes off, counters keep running
- pixels  in  ROWS*COLS*PWM_BITS  frame data; LED i = row + ROWS*col occupies bits [i*PWM_BITS +: PWM_BITS]
- load  in  1  one-cycle strobe, captures pixels into shadow buffer
- pending  out  1  shadow frame waiting for frame boundary
- frame_sync  out  1  one-cycle pulse at every frame boundary
- aled  out  ROWS  anode select, active low
- kled_tri  out  COLS  cathode output-enable, active high (pad drives constant 1)

## Operation
- Counters: prescaler p 0..SCAN_DIV-1; tick t 0..2^PWM_BITS-1 advances when p wraps; slot s 0..ROWS*COLS-1 advances when t wraps and p wraps; s wraps to 0 (frame boundary).
- Slot mapping: row = s mod ROWS, col = s / ROWS (slot 0 = row0/col0, slot 1 = row1/col0, …), matching the legacy 4x4 ordering.
- Level L = active[s]; LED is on when en=1 and t < L. L=0 is always off. L=2^PWM_BITS-1 is on for (2^P-1)/2^P of the slot. Exactly one LED can be lit at a time.
- aled: bit row = 0, all other bits = 1, for the whole slot, independent of L and en. kled_tri: bit col = on, all other bits = 0.
- Buffering: on load, shadow <= pixels and pending <= 1. The boundary cycle is the cycle where p, t and s are all at their maximum. On that cycle, if pending=1, active <= shadow and pending <= 0. frame_sync is asserted for that cycle's registered outcome.
- Simultaneous load and boundary: active takes the old shadow, shadow takes the new pixels, and pending stays 1 (the new frame is shown next boundary). If pending=0 at that point, active is unchanged and the new frame waits one full frame.
- Repeated load before a boundary: last load wins.

## Timing
- All outputs are registered and reflect the counter state of the previous cycle (1-cycle latency).
- Reset (rst sampled high at an edge): p, t, s = 0; active and shadow = 0; pending=0; frame_sync=0; aled = all ones; kled_tri = 0. This holds for every cycle rst is high, and reset mid-frame discards the frame in progress.
- First post-reset edge: aled = ~1 (row 0 selected), kled_tri = 0 (all levels 0).
- Slot length = 2^PWM_BITS*SCAN_DIV cycles. Frame length = ROWS*COLS*2^PWM_BITS*SCAN_DIV cycles (8192 at defaults, 5.86 kHz).
- pending rises the edge after load. The new frame appears on outputs from the first cycle of slot 0 after the boundary.
- frame_sync period equals the frame length exactly, and pulses even when no load is pending.
- en changes take effect on kled_tri with 1-cycle latency and do not affect the counters.

## Test plan
Use ROWS=4, COLS=4, PWM_BITS=4, SCAN_DIV=2 (32-cycle slot, 512-cycle frame).
- Reset mid-frame, hold 3 cycles, release -> aled=4'b1111 and kled_tri=0 during reset; next edge aled=4'b1110, kled_tri=0; frame_sync first pulses 512 cycles later, then every 512.
- Load LED5 (row1/col1) = 8, all others 0 -> pending=1 until the boundary. In the next frame kled_tri=4'b0010 only during slot 5, for 16 cycles at the start of the slot (ticks 0-7), with aled=4'b1101 throughout slot 5.
- Levels 0, 1, 15 on LEDs 0, 1, 2 -> on-cycle counts per frame are 0, 2 and 30 respectively; never more than one kled_tri bit set; aled is one-cold in every cycle.
- Load asserted on the boundary cycle, with a prior pending frame A and new frame B -> A is displayed next frame, pending stays 1, and B is displayed one frame later.
- Two loads (C then D) within one frame -> only D is displayed. en=0 for a full frame -> kled_tri=0 throughout and frame_sync cadence is unchanged.
- All LEDs = 15 with en=1 -> each cathode enable is high for 30 of every 32 cycles within its slots; the frame wraps from s=15 back to s=0 with aled=4'b1110.
